// File: rtl/game_pkg.sv
// Shared arena constants for the game's motion and rendering blocks.
package game_pkg;

  // Visible raster
  localparam int ARENA_W = 640;
  localparam int ARENA_H = 480;

  // Inclusive playfield clamp limits per axis
  localparam int X_MIN_DEF = 0;
  localparam int X_MAX_DEF = 576;
  localparam int Y_MIN_DEF = 100;
  localparam int Y_MAX_DEF = 448;

  // Default pixels per detent and the |acc| that doubles it when acceleration is built in
  localparam int STEP_DEF     = 4;
  localparam int ACCEL_THRESH = 4;

endpackage

// File: rtl/quad_decoder.sv
// Quadrature synchronizer + decoder for one rotary channel.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   rota, rotb    : raw asynchronous quadrature phases
//   det           : one-cycle pulse, one legal transition seen (registered)
//   dir_up        : direction of that transition, 1 = +1 (valid with det)
//   err           : one-cycle pulse, both phases changed together (registered)
module quad_decoder (
  input  logic clk,
  input  logic reset,
  input  logic rota,
  input  logic rotb,
  output logic det,
  output logic dir_up,
  output logic err
);

  localparam logic [1:0] ARM_DONE = 2'd3;

  logic [2:0] sync_a_q, sync_a_d;
  logic [2:0] sync_b_q, sync_b_d;
  logic [1:0] arm_q, arm_d;
  logic       det_q, det_d;
  logic       dir_q, dir_d;
  logic       err_q, err_d;
  logic       chg_a, chg_b, armed;

  // Stage [1] is the newest settled sample, stage [2] the previous one.
  // Compares stay off until the chain holds only post-reset samples, so the
  // zeroed history can never be mistaken for a detent or an error.
  always_comb begin
    sync_a_d = {sync_a_q[1:0], rota};
    sync_b_d = {sync_b_q[1:0], rotb};
    arm_d    = (arm_q == ARM_DONE) ? arm_q : arm_q + 2'd1;
    armed    = (arm_q == ARM_DONE);
    chg_a    = sync_a_q[2] ^ sync_a_q[1];
    chg_b    = sync_b_q[2] ^ sync_b_q[1];
    det_d    = armed & (chg_a ^ chg_b);
    dir_d    = sync_a_q[2] ^ sync_b_q[1];
    err_d    = armed & chg_a & chg_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      arm_q    <= '0;
      det_q    <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync_a_q <= sync_a_d;
      sync_b_q <= sync_b_d;
      arm_q    <= arm_d;
      det_q    <= det_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
    end
  end

  assign det    = det_q;
  assign dir_up = dir_q;
  assign err    = err_q;

endmodule

// File: rtl/ship_motion_ctrl.sv
// Per-frame ship motion from rotary quadrature controls.
// Detents accumulate (saturating) during a frame; on frame_tick the position
// moves by acc*STEP and is clamped to the channel's axis limits.
// Build option: define SHIP_ACCEL_EN to double the per-detent step when
// |acc| >= 4 at frame_tick.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   rota, rotb  : [N_CH] raw quadrature phases
//   frame_tick  : one-cycle end-of-frame strobe
//   enable      : movement enable (low on title screen)
//   pos         : [N_CH*POS_W] registered positions, channel 0 in LSBs
//   moved       : [N_CH] pulse, position changed on the last tick
//   quad_err    : [N_CH] pulse, illegal quadrature transition
module ship_motion_ctrl
  import game_pkg::*;
#(
  parameter int unsigned          N_CH     = 2,
  parameter int unsigned          POS_W    = 10,
  parameter int unsigned          STEP     = STEP_DEF,
  parameter logic [N_CH-1:0]      AXIS_Y   = 2'b10,
  parameter int                   X_MIN    = X_MIN_DEF,
  parameter int                   X_MAX    = X_MAX_DEF,
  parameter int                   Y_MIN    = Y_MIN_DEF,
  parameter int                   Y_MAX    = Y_MAX_DEF,
  parameter logic [N_CH*POS_W-1:0] INIT_POS = {10'd224, 10'd288},
  parameter int                   ACC_MAX  = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        rota,
  input  logic [N_CH-1:0]        rotb,
  input  logic                   frame_tick,
  input  logic                   enable,
  output logic [N_CH*POS_W-1:0]  pos,
  output logic [N_CH-1:0]        moved,
  output logic [N_CH-1:0]        quad_err
);

  localparam int unsigned CALC_W = POS_W + 5;
  localparam int unsigned ACC_W  = $clog2(ACC_MAX + 1) + 1;

  logic [N_CH-1:0] det, dir_up, err;

  logic signed [ACC_W-1:0] acc_q [N_CH];
  logic signed [ACC_W-1:0] acc_d [N_CH];
  logic [POS_W-1:0]        pos_q [N_CH];
  logic [POS_W-1:0]        pos_d [N_CH];
  logic [N_CH-1:0]         moved_q, moved_d;

  // One synchronizer/decoder per channel
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    quad_decoder u_dec (
      .clk    (clk),
      .reset  (reset),
      .rota   (rota[g]),
      .rotb   (rotb[g]),
      .det    (det[g]),
      .dir_up (dir_up[g]),
      .err    (err[g])
    );
    assign pos[g*POS_W +: POS_W] = pos_q[g];
  end

  // Saturating +/-1 on the frame accumulator
  function automatic logic signed [ACC_W-1:0] acc_step(
    input logic signed [ACC_W-1:0] a,
    input logic                    up
  );
    logic signed [ACC_W-1:0] lim;
    lim = ACC_W'(ACC_MAX);
    if (up) acc_step = (a >= lim)  ? a : a + ACC_W'(1);
    else    acc_step = (a <= -lim) ? a : a - ACC_W'(1);
  endfunction

  // New position in widened signed math so over/underflow clamps instead of wrapping
  function automatic logic [POS_W-1:0] next_pos(
    input logic [POS_W-1:0]        p,
    input logic signed [ACC_W-1:0] a,
    input logic                    is_y
  );
    logic signed [CALC_W-1:0] p_x, a_x, s_x, lo, hi, sum;
    p_x = $signed(CALC_W'(p));
    a_x = CALC_W'(a);
    s_x = $signed(CALC_W'(STEP));
`ifdef SHIP_ACCEL_EN
    if ((a_x >= $signed(CALC_W'(ACCEL_THRESH))) || (a_x <= -$signed(CALC_W'(ACCEL_THRESH))))
      s_x = s_x + s_x;
`endif
    lo  = is_y ? CALC_W'(Y_MIN) : CALC_W'(X_MIN);
    hi  = is_y ? CALC_W'(Y_MAX) : CALC_W'(X_MAX);
    sum = p_x + a_x * s_x;
    if (sum < lo)      sum = lo;
    else if (sum > hi) sum = hi;
    next_pos = POS_W'(sum);
  endfunction

  // Frame accumulation and tick-time position update
  always_comb begin
    moved_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      acc_d[i] = acc_q[i];
      pos_d[i] = pos_q[i];
      if (!enable) begin
        acc_d[i] = '0;
      end else if (frame_tick) begin
        pos_d[i]   = next_pos(pos_q[i], acc_q[i], AXIS_Y[i]);
        moved_d[i] = (pos_d[i] != pos_q[i]);
        // A detent landing on the tick seeds the next frame
        acc_d[i]   = det[i] ? (dir_up[i] ? ACC_W'(1) : -ACC_W'(1)) : '0;
      end else if (det[i]) begin
        acc_d[i] = acc_step(acc_q[i], dir_up[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        acc_q[i] <= '0;
        pos_q[i] <= INIT_POS[i*POS_W +: POS_W];
      end
      moved_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        acc_q[i] <= acc_d[i];
        pos_q[i] <= pos_d[i];
      end
      moved_q <= moved_d;
    end
  end

  assign moved    = moved_q;
  assign quad_err = err;

endmodule

// File: tb/tb_ship_motion_ctrl.sv
// Self-checking bench for ship_motion_ctrl (default parameters, 2 channels).
module tb_ship_motion_ctrl;

  localparam int STEP   = 4;
  localparam int X_MIN  = 0;
  localparam int X_MAX  = 576;
  localparam int Y_MIN  = 100;
  localparam int Y_MAX  = 448;
  localparam int ACCMAX = 7;
  localparam int INIT0  = 288;
  localparam int INIT1  = 224;

  typedef struct packed {
    logic [19:0] pos;
    logic [1:0]  moved;
    logic        chk_pos;
    logic        chk_moved;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rota, rotb;
  logic        frame_tick, enable;
  logic [19:0] pos;
  logic [1:0]  moved, quad_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic tick_dly;

  int exp_pos[2];
  int exp_acc[2];
  int gidx[2];

  ship_motion_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rota       (rota),
    .rotb       (rotb),
    .frame_tick (frame_tick),
    .enable     (enable),
    .pos        (pos),
    .moved      (moved),
    .quad_err   (quad_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: results appear the cycle after frame_tick
  always @(posedge clk or posedge reset) begin
    if (reset) tick_dly <= 1'b0;
    else       tick_dly <= frame_tick;
  end

  always @(negedge clk) begin
    if (tick_dly) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk_pos)   check("pos", 32'(pos), 32'(mon_e.pos));
        if (mon_e.chk_moved) check("moved", 32'(moved), 32'(mon_e.moved));
      end
    end
  end

  function automatic int model_next(input int p, input int a, input int ch);
    int st, n, lo, hi;
    st = STEP;
`ifdef SHIP_ACCEL_EN
    if (a >= 4 || a <= -4) st = 2 * STEP;
`endif
    lo = (ch == 1) ? Y_MIN : X_MIN;
    hi = (ch == 1) ? Y_MAX : X_MAX;
    n  = p + a * st;
    if (n < lo) n = lo;
    if (n > hi) n = hi;
    return n;
  endfunction

  // Gray order 00,01,11,10 is the +1 (clockwise) direction
  task automatic drive_ch(input int ch);
    rota[ch] = (gidx[ch] == 2) || (gidx[ch] == 3);
    rotb[ch] = (gidx[ch] == 1) || (gidx[ch] == 2);
  endtask

  task automatic detent(input int ch, input bit up);
    gidx[ch] = up ? (gidx[ch] + 1) % 4 : (gidx[ch] + 3) % 4;
    drive_ch(ch);
    if (enable) begin
      if (up && exp_acc[ch] < ACCMAX)   exp_acc[ch]++;
      if (!up && exp_acc[ch] > -ACCMAX) exp_acc[ch]--;
    end
    @(negedge clk);
  endtask

  task automatic do_tick(input bit chk_moved);
    exp_t e;
    int   np;
    repeat (6) @(negedge clk);
    e.moved = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (enable) begin
        np          = model_next(exp_pos[ch], exp_acc[ch], ch);
        e.moved[ch] = (np != exp_pos[ch]);
        exp_pos[ch] = np;
      end
      exp_acc[ch] = 0;
    end
    e.pos       = {10'(exp_pos[1]), 10'(exp_pos[0])};
    e.chk_pos   = 1'b1;
    e.chk_moved = chk_moved;
    sb.push_back(e);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    check("moved_clear", 32'(moved), 32'd0);
  endtask

  // Tick with no expectation: frame contents are timing-dependent
  task automatic raw_tick();
    exp_t e;
    e = '0;
    sb.push_back(e);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic model_reset();
    exp_pos[0] = INIT0;
    exp_pos[1] = INIT1;
    exp_acc[0] = 0;
    exp_acc[1] = 0;
  endtask

  initial begin
    bit seen;
    reset = 1'b1; rota = '0; rotb = '0; frame_tick = 1'b0; enable = 1'b1;
    gidx[0] = 0; gidx[1] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pos", 32'(pos), {12'd0, 10'd224, 10'd288});
    check("rst_moved", 32'(moved), 32'd0);
    check("rst_qerr", 32'(quad_err), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Idle frame: nothing moves
    do_tick(1'b1);

    // Three clockwise detents on ch0 -> 300
    for (int j = 0; j < 3; j++) detent(0, 1'b1);
    do_tick(1'b1);
    check("ch0_300", 32'(pos[9:0]), 32'd300);

    // Two detents, then an illegal double change that must not disturb acc
    detent(0, 1'b1);
    detent(0, 1'b1);
    gidx[0] = (gidx[0] + 2) % 4;
    drive_ch(0);
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (quad_err[0]) seen = 1'b1;
    end
    check("qerr_pulse", 32'(seen), 32'd1);
    check("qerr_ch1_quiet", 32'(quad_err[1]), 32'd0);
    @(negedge clk);
    check("qerr_one_cycle", 32'(quad_err[0]), 32'd0);
    do_tick(1'b1);
    check("ch0_after_err", 32'(pos[9:0]), 32'd308);

    // Ten detents saturate acc at 7
    for (int j = 0; j < 10; j++) detent(0, 1'b1);
    do_tick(1'b1);
`ifdef SHIP_ACCEL_EN
    check("ch0_sat", 32'(pos[9:0]), 32'd364);
`else
    check("ch0_sat", 32'(pos[9:0]), 32'd336);
`endif

    // A detent near the tick is carried into a frame, never dropped
    for (int k = 0; k < 5; k++) begin
      gidx[0] = (gidx[0] + 1) % 4;
      drive_ch(0);
      repeat (k) @(negedge clk);
      raw_tick();
      exp_acc[0] = 1;
      do_tick(1'b0);
    end
`ifdef SHIP_ACCEL_EN
    check("ch0_no_loss", 32'(pos[9:0]), 32'd384);
`else
    check("ch0_no_loss", 32'(pos[9:0]), 32'd356);
`endif

    // Walk ch1 up to 104 in small frames
    while (exp_pos[1] > 104) begin
      int n;
      n = (exp_pos[1] - 104) / STEP;
      if (n > 3) n = 3;
      for (int j = 0; j < n; j++) detent(1, 1'b0);
      do_tick(1'b1);
    end
    check("ch1_104", 32'(pos[19:10]), 32'd104);
    for (int j = 0; j < 5; j++) detent(1, 1'b0);
    do_tick(1'b1);
    check("ch1_clamp", 32'(pos[19:10]), 32'd100);

    // Disabled: detents discarded, nothing moves, even after re-enable
    enable = 1'b0;
    for (int j = 0; j < 4; j++) detent(0, 1'b1);
    do_tick(1'b1);
    enable = 1'b1;
    do_tick(1'b1);

    // Reset mid-frame with phases left high
    for (int j = 0; j < 3; j++) detent(0, 1'b1);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("midrst_pos", 32'(pos), {12'd0, 10'd224, 10'd288});
    check("midrst_moved", 32'(moved), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (quad_err != 2'b00) seen = 1'b1;
    end
    check("post_rst_no_err", 32'(seen), 32'd0);
    do_tick(1'b1);
    check("post_rst_pos", 32'(pos), {12'd0, 10'd224, 10'd288});
    detent(0, 1'b1);
    detent(0, 1'b1);
    do_tick(1'b1);
    check("post_rst_move", 32'(pos[9:0]), 32'd296);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
